// File: rtl/fft_state3.sv
// Third radix-2 stage of the 32-point MDC FFT: scaled butterfly, W8 twiddle on the
// difference path, and a delay-switch-delay commutator that regroups lanes for stage 4.
module fft_state3 #(
    parameter int WIDTH = 9,
    parameter int DELAY = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_up_re,
    input  logic signed [WIDTH-1:0] in_up_im,
    input  logic signed [WIDTH-1:0] in_lo_re,
    input  logic signed [WIDTH-1:0] in_lo_im,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] out_up_re,
    output logic signed [WIDTH-1:0] out_up_im,
    output logic signed [WIDTH-1:0] out_lo_re,
    output logic signed [WIDTH-1:0] out_lo_im
);

    localparam int PH = $clog2(DELAY);
    localparam int PW = WIDTH + 10;
    localparam int CW = 2 * WIDTH;
    localparam logic signed [PW-1:0] RND    = PW'(64);
    localparam logic signed [PW-1:0] SAT_HI = PW'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [PW-1:0] SAT_LO = ~SAT_HI;

    // ---------------- R1: input register ----------------
    logic                    v1_q;
    logic signed [WIDTH-1:0] u1_re_q, u1_im_q, l1_re_q, l1_im_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            u1_re_q <= '0;
            u1_im_q <= '0;
            l1_re_q <= '0;
            l1_im_q <= '0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                u1_re_q <= in_up_re;
                u1_im_q <= in_up_im;
                l1_re_q <= in_lo_re;
                l1_im_q <= in_lo_im;
            end
        end
    end

    // ---------------- R2: butterfly with 1/2 scaling ----------------
    logic signed [WIDTH:0] sum_re_d, sum_im_d, dif_re_d, dif_im_d;

    assign sum_re_d = {u1_re_q[WIDTH-1], u1_re_q} + {l1_re_q[WIDTH-1], l1_re_q};
    assign sum_im_d = {u1_im_q[WIDTH-1], u1_im_q} + {l1_im_q[WIDTH-1], l1_im_q};
    assign dif_re_d = {u1_re_q[WIDTH-1], u1_re_q} - {l1_re_q[WIDTH-1], l1_re_q};
    assign dif_im_d = {u1_im_q[WIDTH-1], u1_im_q} - {l1_im_q[WIDTH-1], l1_im_q};

    logic                    v2_q;
    logic signed [WIDTH-1:0] s2_re_q, s2_im_q, d2_re_q, d2_im_q;
    logic [3:0]              idx_q, idx_d;

    // Frame position of the sample sitting in R2; 16 pairs per 32-point frame.
    assign idx_d = (idx_q == 4'd15) ? 4'd0 : idx_q + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q    <= 1'b0;
            idx_q   <= '0;
            s2_re_q <= '0;
            s2_im_q <= '0;
            d2_re_q <= '0;
            d2_im_q <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                s2_re_q <= WIDTH'(sum_re_d >>> 1);
                s2_im_q <= WIDTH'(sum_im_d >>> 1);
                d2_re_q <= WIDTH'(dif_re_d >>> 1);
                d2_im_q <= WIDTH'(dif_im_d >>> 1);
            end
            if (v2_q) begin
                idx_q <= idx_d;
            end
        end
    end

    // ---------------- Twiddle W8^k, Q1.7 ----------------
    logic signed [8:0] w_re, w_im;

    always_comb begin
        w_re = 9'sd128;
        w_im = 9'sd0;
        case (idx_q[1:0])
            2'd0: begin w_re = 9'sd128;  w_im = 9'sd0;    end
            2'd1: begin w_re = 9'sd91;   w_im = -9'sd91;  end
            2'd2: begin w_re = 9'sd0;    w_im = -9'sd128; end
            2'd3: begin w_re = -9'sd91;  w_im = -9'sd91;  end
            default: begin w_re = 9'sd128; w_im = 9'sd0; end
        endcase
    end

    // ---------------- Complex multiply, round, saturate ----------------
    logic signed [PW-1:0] dre_x, dim_x, wre_x, wim_x;
    logic signed [PW-1:0] acc_re, acc_im, rnd_re, rnd_im;
    logic signed [WIDTH-1:0] y_re_d, y_im_d;

    assign dre_x = {{(PW-WIDTH){d2_re_q[WIDTH-1]}}, d2_re_q};
    assign dim_x = {{(PW-WIDTH){d2_im_q[WIDTH-1]}}, d2_im_q};
    assign wre_x = {{(PW-9){w_re[8]}}, w_re};
    assign wim_x = {{(PW-9){w_im[8]}}, w_im};

    assign acc_re = dre_x * wre_x - dim_x * wim_x + RND;
    assign acc_im = dre_x * wim_x + dim_x * wre_x + RND;
    assign rnd_re = acc_re >>> 7;
    assign rnd_im = acc_im >>> 7;

    always_comb begin
        y_re_d = WIDTH'(rnd_re);
        y_im_d = WIDTH'(rnd_im);
        if (rnd_re > SAT_HI) begin
            y_re_d = WIDTH'(SAT_HI);
        end else if (rnd_re < SAT_LO) begin
            y_re_d = WIDTH'(SAT_LO);
        end
        if (rnd_im > SAT_HI) begin
            y_im_d = WIDTH'(SAT_HI);
        end else if (rnd_im < SAT_LO) begin
            y_im_d = WIDTH'(SAT_LO);
        end
    end

    // ---------------- R3: s realigned with twiddled d ----------------
    logic                    v3_q;
    logic signed [WIDTH-1:0] x_re_q, x_im_q, y_re_q, y_im_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_q   <= 1'b0;
            x_re_q <= '0;
            x_im_q <= '0;
            y_re_q <= '0;
            y_im_q <= '0;
        end else begin
            v3_q <= v2_q;
            if (v2_q) begin
                x_re_q <= s2_re_q;
                x_im_q <= s2_im_q;
                y_re_q <= y_re_d;
                y_im_q <= y_im_d;
            end
        end
    end

    // ---------------- Commutator and output register ----------------
    logic [CW-1:0] yd_q [DELAY];
    logic [CW-1:0] td_q [DELAY];
    logic [PH:0]   t_q;
    logic          primed_q;
    logic          out_valid_q;
    logic [CW-1:0] out_up_q, out_lo_q;
    logic [CW-1:0] x_c, y_c, top_c, bot_c;
    logic          phase;

    assign x_c   = {x_re_q, x_im_q};
    assign y_c   = {y_re_q, y_im_q};
    assign phase = t_q[PH];
    // Phase 1 crosses the delayed y stream into the upper path.
    assign top_c = phase ? yd_q[DELAY-1] : x_c;
    assign bot_c = phase ? x_c : yd_q[DELAY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DELAY; i++) begin
                yd_q[i] <= '0;
                td_q[i] <= '0;
            end
            t_q         <= '0;
            primed_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_up_q    <= '0;
            out_lo_q    <= '0;
        end else begin
            out_valid_q <= v3_q & primed_q;
            if (v3_q) begin
                for (int i = DELAY - 1; i > 0; i--) begin
                    yd_q[i] <= yd_q[i-1];
                    td_q[i] <= td_q[i-1];
                end
                yd_q[0]  <= y_c;
                td_q[0]  <= top_c;
                t_q      <= t_q + (PH+1)'(1);
                out_up_q <= td_q[DELAY-1];
                out_lo_q <= bot_c;
                if (t_q == (PH+1)'(DELAY - 1)) begin
                    primed_q <= 1'b1;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_up_re = out_up_q[CW-1:WIDTH];
    assign out_up_im = out_up_q[WIDTH-1:0];
    assign out_lo_re = out_lo_q[CW-1:WIDTH];
    assign out_lo_im = out_lo_q[WIDTH-1:0];

endmodule

// File: tb/tb_fft_state3.sv
// Self-checking bench for fft_state3: randomized and directed streams compared against
// a slot-level reference model of butterfly, twiddle and commutator output order.
module tb_fft_state3;

    localparam int W = 9;
    localparam int D = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                in_valid = 1'b0;
    logic signed [W-1:0] in_up_re = '0, in_up_im = '0, in_lo_re = '0, in_lo_im = '0;
    logic                out_valid;
    logic signed [W-1:0] out_up_re, out_up_im, out_lo_re, out_lo_im;

    fft_state3 #(.WIDTH(W), .DELAY(D)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_up_re(in_up_re), .in_up_im(in_up_im), .in_lo_re(in_lo_re), .in_lo_im(in_lo_im),
        .out_valid(out_valid),
        .out_up_re(out_up_re), .out_up_im(out_up_im), .out_lo_re(out_lo_re), .out_lo_im(out_lo_im)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;
    int t_cnt = 0;
    int xr[64], xi[64], yr[64], yi[64];
    bit pv[8];
    int pur[8], pui[8], plr[8], pli[8];
    bit exp_v;
    int e_ur, e_ui, e_lr, e_li;
    int WR[4] = '{128, 91, 0, -91};
    int WI[4] = '{0, -91, -128, -91};

    function automatic int rnd9();
        return int'($urandom_range(511)) - 256;
    endfunction

    function automatic int sat9(input int v);
        if (v > 255) return 255;
        if (v < -256) return -256;
        return v;
    endfunction

    task automatic clear_model();
        t_cnt = 0;
        for (int i = 0; i < 8; i++) pv[i] = 1'b0;
    endtask

    // Sample t feeds slot t; slot t (t >= D) shows x pairs in cross phase, y pairs otherwise.
    task automatic model_push(input int ur, input int ui, input int lr, input int li);
        int t, k, dr, di, s;
        t  = t_cnt;
        k  = (t % 16) % 4;
        dr = (ur - lr) >>> 1;
        di = (ui - li) >>> 1;
        xr[t % 64] = (ur + lr) >>> 1;
        xi[t % 64] = (ui + li) >>> 1;
        yr[t % 64] = sat9((dr * WR[k] - di * WI[k] + 64) >>> 7);
        yi[t % 64] = sat9((dr * WI[k] + di * WR[k] + 64) >>> 7);
        if (t >= D) begin
            s = (cyc + 3) % 8;
            pv[s] = 1'b1;
            if (((t / D) % 2) == 1) begin
                pur[s] = xr[(t - D) % 64]; pui[s] = xi[(t - D) % 64];
                plr[s] = xr[t % 64];       pli[s] = xi[t % 64];
            end else begin
                pur[s] = yr[(t - 2 * D) % 64]; pui[s] = yi[(t - 2 * D) % 64];
                plr[s] = yr[(t - D) % 64];     pli[s] = yi[(t - D) % 64];
            end
        end
        t_cnt++;
    endtask

    task automatic step(input bit v, input int ur, input int ui, input int lr, input int li);
        int s;
        in_valid = v;
        in_up_re = W'(ur); in_up_im = W'(ui);
        in_lo_re = W'(lr); in_lo_im = W'(li);
        @(posedge clk);
        cyc++;
        if (v && rst_n) model_push(ur, ui, lr, li);
        @(negedge clk);
        s = cyc % 8;
        exp_v = pv[s];
        e_ur = pur[s]; e_ui = pui[s]; e_lr = plr[s]; e_li = pli[s];
        pv[s] = 1'b0;
        if (out_valid === 1'b1)
            $display("cyc=%0d out up=(%0d,%0d) lo=(%0d,%0d)", cyc, out_up_re, out_up_im, out_lo_re, out_lo_im);
    endtask

    task automatic quiet_reset();
        rst_n = 1'b0;
        clear_model();
        step(1'b0, 0, 0, 0, 0);
        step(1'b0, 0, 0, 0, 0);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int first;
        rst_n = 1'b0;
        clear_model();
        for (int i = 0; i < 8; i++) begin
            step(1'($urandom_range(1)), rnd9(), rnd9(), rnd9(), rnd9());
            n_vec++;
            if (out_valid !== 1'b0 || out_up_re !== 0 || out_up_im !== 0 || out_lo_re !== 0 || out_lo_im !== 0) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d got v=%0b (%0d,%0d)(%0d,%0d) want all 0", cyc, out_valid, out_up_re, out_up_im, out_lo_re, out_lo_im);
            end
        end
        rst_n = 1'b1;
        first = -1;
        for (int i = 0; i < 14; i++) begin
            step(1'b1, rnd9(), rnd9(), rnd9(), rnd9());
            if (out_valid === 1'b1 && first < 0) first = i;
            n_vec++;
            if (out_valid !== exp_v || (exp_v && (out_up_re !== e_ur || out_up_im !== e_ui || out_lo_re !== e_lr || out_lo_im !== e_li))) begin
                n_fail++;
                $display("FAIL reset_stream cyc=%0d got v=%0b (%0d,%0d)(%0d,%0d) want v=%0b (%0d,%0d)(%0d,%0d)", cyc, out_valid, out_up_re, out_up_im, out_lo_re, out_lo_im, exp_v, e_ur, e_ui, e_lr, e_li);
            end
        end
        n_vec++;
        if (first != D + 3) begin
            n_fail++;
            $display("FAIL first_valid got step %0d want step %0d", first, D + 3);
        end
    endtask

    task automatic test_const();
        int n;
        int cu_re[4] = '{60, 60, 40, 28};
        int cu_im[4] = '{0, 0, 0, -28};
        int cl_re[4] = '{60, 60, 0, -28};
        int cl_im[4] = '{0, 0, -40, -28};
        quiet_reset();
        n = 0;
        for (int i = 0; i < 26; i++) begin
            step(1'b1, 100, 0, 20, 0);
            n_vec++;
            if (out_valid !== exp_v || (exp_v && (out_up_re !== e_ur || out_up_im !== e_ui || out_lo_re !== e_lr || out_lo_im !== e_li))) begin
                n_fail++;
                $display("FAIL const_model cyc=%0d got v=%0b (%0d,%0d)(%0d,%0d) want v=%0b (%0d,%0d)(%0d,%0d)", cyc, out_valid, out_up_re, out_up_im, out_lo_re, out_lo_im, exp_v, e_ur, e_ui, e_lr, e_li);
            end
            if (out_valid === 1'b1) begin
                n_vec++;
                if (out_up_re !== cu_re[n % 4] || out_up_im !== cu_im[n % 4] || out_lo_re !== cl_re[n % 4] || out_lo_im !== cl_im[n % 4]) begin
                    n_fail++;
                    $display("FAIL const_table slot=%0d got (%0d,%0d)(%0d,%0d) want (%0d,%0d)(%0d,%0d)", n + D, out_up_re, out_up_im, out_lo_re, out_lo_im, cu_re[n % 4], cu_im[n % 4], cl_re[n % 4], cl_im[n % 4]);
                end
                n++;
            end
        end
    endtask

    task automatic test_ramp();
        int n, t;
        quiet_reset();
        n = 0;
        for (int i = 0; i < 36; i++) begin
            if (i < 32) step(1'b1, 2 * i, 0, 0, 0);
            else        step(1'b0, 0, 0, 0, 0);
            n_vec++;
            if (out_valid !== exp_v || (exp_v && (out_up_re !== e_ur || out_up_im !== e_ui || out_lo_re !== e_lr || out_lo_im !== e_li))) begin
                n_fail++;
                $display("FAIL ramp_model cyc=%0d got v=%0b (%0d,%0d)(%0d,%0d) want v=%0b (%0d,%0d)(%0d,%0d)", cyc, out_valid, out_up_re, out_up_im, out_lo_re, out_lo_im, exp_v, e_ur, e_ui, e_lr, e_li);
            end
            if (out_valid === 1'b1) begin
                t = n + D;
                if ((t % 4) == 2 || (t % 4) == 3) begin
                    n_vec++;
                    if (out_up_re !== t - 2 || out_lo_re !== t || out_up_im !== 0 || out_lo_im !== 0) begin
                        n_fail++;
                        $display("FAIL ramp_pair slot=%0d got (%0d,%0d)(%0d,%0d) want (%0d,0)(%0d,0)", t, out_up_re, out_up_im, out_lo_re, out_lo_im, t - 2, t);
                    end
                end
                n++;
            end
        end
    endtask

    task automatic test_saturation();
        int n, t;
        quiet_reset();
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (i >= 12)          step(1'b0, 0, 0, 0, 0);
            else if (i % 4 == 2)  step(1'b1, -256, 0, 255, 0);
            else                  step(1'b1, rnd9(), rnd9(), rnd9(), rnd9());
            n_vec++;
            if (out_valid !== exp_v || (exp_v && (out_up_re !== e_ur || out_up_im !== e_ui || out_lo_re !== e_lr || out_lo_im !== e_li))) begin
                n_fail++;
                $display("FAIL sat_model cyc=%0d got v=%0b (%0d,%0d)(%0d,%0d) want v=%0b (%0d,%0d)(%0d,%0d)", cyc, out_valid, out_up_re, out_up_im, out_lo_re, out_lo_im, exp_v, e_ur, e_ui, e_lr, e_li);
            end
            if (out_valid === 1'b1) begin
                t = n + D;
                if ((t % 4) == 0) begin
                    n_vec++;
                    if (out_lo_re !== 0 || out_lo_im !== 255) begin
                        n_fail++;
                        $display("FAIL sat_clip slot=%0d got lo=(%0d,%0d) want lo=(0,255)", t, out_lo_re, out_lo_im);
                    end
                end
                n++;
            end
        end
    endtask

    task automatic test_gap();
        int dur[40], dui[40], dlr[40], dli[40];
        logic [4*W-1:0] q0[$], q1[$];
        int si, last, holes;
        bit gap;
        for (int i = 0; i < 40; i++) begin
            dur[i] = rnd9(); dui[i] = rnd9(); dlr[i] = rnd9(); dli[i] = rnd9();
        end
        for (int r = 0; r < 2; r++) begin
            quiet_reset();
            si = 0; last = -1; holes = 0;
            for (int j = 0; j < 49; j++) begin
                gap = (r == 1) && (j >= 17) && (j < 22);
                if (!gap && si < 40) begin
                    step(1'b1, dur[si], dui[si], dlr[si], dli[si]);
                    si++;
                end else begin
                    step(1'b0, rnd9(), rnd9(), rnd9(), rnd9());
                end
                n_vec++;
                if (out_valid !== exp_v || (exp_v && (out_up_re !== e_ur || out_up_im !== e_ui || out_lo_re !== e_lr || out_lo_im !== e_li))) begin
                    n_fail++;
                    $display("FAIL gap_model run=%0d cyc=%0d got v=%0b (%0d,%0d)(%0d,%0d) want v=%0b (%0d,%0d)(%0d,%0d)", r, cyc, out_valid, out_up_re, out_up_im, out_lo_re, out_lo_im, exp_v, e_ur, e_ui, e_lr, e_li);
                end
                if (out_valid === 1'b1) begin
                    if (last >= 0) holes += j - last - 1;
                    last = j;
                    if (r == 0) q0.push_back({out_up_re, out_up_im, out_lo_re, out_lo_im});
                    else        q1.push_back({out_up_re, out_up_im, out_lo_re, out_lo_im});
                end
            end
            n_vec++;
            if (holes != 5 * r) begin
                n_fail++;
                $display("FAIL gap_holes run=%0d got %0d idle output cycles want %0d", r, holes, 5 * r);
            end
        end
        n_vec++;
        if (q0.size() != q1.size() || q0.size() != 40 - D) begin
            n_fail++;
            $display("FAIL gap_count got %0d and %0d outputs want %0d", q0.size(), q1.size(), 40 - D);
        end
        for (int i = 0; i < q0.size() && i < q1.size(); i++) begin
            n_vec++;
            if (q1[i] !== q0[i]) begin
                n_fail++;
                $display("FAIL gap_seq idx=%0d got %h want %h", i, q1[i], q0[i]);
            end
        end
    endtask

    task automatic test_midreset();
        int first;
        quiet_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, rnd9(), rnd9(), rnd9(), rnd9());
        end
        #2 rst_n = 1'b0;
        clear_model();
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_up_re !== 0 || out_up_im !== 0 || out_lo_re !== 0 || out_lo_im !== 0) begin
            n_fail++;
            $display("FAIL midreset_async got v=%0b (%0d,%0d)(%0d,%0d) want all 0", out_valid, out_up_re, out_up_im, out_lo_re, out_lo_im);
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, rnd9(), rnd9(), rnd9(), rnd9());
            n_vec++;
            if (out_valid !== 1'b0 || out_up_re !== 0 || out_lo_re !== 0) begin
                n_fail++;
                $display("FAIL midreset_hold got v=%0b up=%0d lo=%0d want 0", out_valid, out_up_re, out_lo_re);
            end
        end
        rst_n = 1'b1;
        first = -1;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, rnd9(), rnd9(), rnd9(), rnd9());
            if (out_valid === 1'b1 && first < 0) first = i;
            n_vec++;
            if (out_valid !== exp_v || (exp_v && (out_up_re !== e_ur || out_up_im !== e_ui || out_lo_re !== e_lr || out_lo_im !== e_li))) begin
                n_fail++;
                $display("FAIL midreset_stream cyc=%0d got v=%0b (%0d,%0d)(%0d,%0d) want v=%0b (%0d,%0d)(%0d,%0d)", cyc, out_valid, out_up_re, out_up_im, out_lo_re, out_lo_im, exp_v, e_ur, e_ui, e_lr, e_li);
            end
        end
        n_vec++;
        if (first != D + 3) begin
            n_fail++;
            $display("FAIL midreset_first got step %0d want step %0d", first, D + 3);
        end
    endtask

    task automatic test_random();
        quiet_reset();
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(3) != 0), rnd9(), rnd9(), rnd9(), rnd9());
            n_vec++;
            if (out_valid !== exp_v || (exp_v && (out_up_re !== e_ur || out_up_im !== e_ui || out_lo_re !== e_lr || out_lo_im !== e_li))) begin
                n_fail++;
                $display("FAIL random cyc=%0d got v=%0b (%0d,%0d)(%0d,%0d) want v=%0b (%0d,%0d)(%0d,%0d)", cyc, out_valid, out_up_re, out_up_im, out_lo_re, out_lo_im, exp_v, e_ur, e_ui, e_lr, e_li);
            end
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_const();
        test_ramp();
        test_saturation();
        test_gap();
        test_midreset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
